// File: rtl/atanh_pkg.sv
// Shared types and constants for the piecewise atanh stream: Q-format widths,
// segment encoding, segment bounds/bases and the shift-add magnitude function.
package atanh_pkg;

    localparam int X_W = 8;  // Q0.7 activation in
    localparam int Y_W = 8;  // Q3.5 pre-activation out
    localparam int A_W = 7;  // |x| clamped to 127
    localparam int D_W = 7;  // offset into segment
    localparam int M_W = 8;  // internal unsigned sum width

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5,
        S6 = 3'd6
    } seg_t;

    localparam logic [A_W-1:0] LB_S0 = 7'd0;
    localparam logic [A_W-1:0] LB_S1 = 7'd64;
    localparam logic [A_W-1:0] LB_S2 = 7'd96;
    localparam logic [A_W-1:0] LB_S3 = 7'd112;
    localparam logic [A_W-1:0] LB_S4 = 7'd120;
    localparam logic [A_W-1:0] LB_S5 = 7'd124;
    localparam logic [A_W-1:0] LB_S6 = 7'd127;

    localparam logic [M_W-1:0] BASE_S0 = 8'd0;
    localparam logic [M_W-1:0] BASE_S1 = 8'd17;
    localparam logic [M_W-1:0] BASE_S2 = 8'd31;
    localparam logic [M_W-1:0] BASE_S3 = 8'd43;
    localparam logic [M_W-1:0] BASE_S4 = 8'd55;
    localparam logic [M_W-1:0] BASE_S5 = 8'd66;
    localparam logic [M_W-1:0] BASE_S6 = 8'd89;

    // Slopes grow toward saturation; every term is a shift so no multiplier is inferred.
    function automatic logic [M_W-1:0] seg_mag(seg_t seg, logic [A_W-1:0] a,
                                               logic [D_W-1:0] d);
        logic [M_W-1:0] aa;
        logic [M_W-1:0] dd;
        logic [M_W-1:0] m;
        aa = {1'b0, a};
        dd = {1'b0, d};
        m  = '0;
        case (seg)
            S0: m = BASE_S0 + (aa >> 2) + (aa >> 5);
            S1: m = BASE_S1 + (dd >> 1) - (dd >> 3);
            S2: m = BASE_S2 + (dd >> 1) + (dd >> 2);
            S3: m = BASE_S3 + dd + (dd >> 1);
            S4: m = BASE_S4 + (dd << 1) + dd;
            S5: m = BASE_S5 + (dd << 2) + dd;
            S6: m = BASE_S6;
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/atanh_seg_decode.sv
// Combinational front end: splits a Q0.7 sample into sign, clamped magnitude,
// segment index and offset from the segment lower bound.
module atanh_seg_decode
    import atanh_pkg::*;
(
    input  logic [X_W-1:0] x_i,
    output logic           sign_o,
    output logic [A_W-1:0] a_o,
    output seg_t           seg_o,
    output logic [D_W-1:0] d_o
);

    logic [X_W-1:0] neg_x;
    logic [A_W-1:0] lb;

    assign neg_x  = -x_i;
    assign sign_o = x_i[X_W-1];

    always_comb begin
        // -128 has no positive Q0.7 counterpart; fold it onto 127.
        if (x_i == 8'h80)
            a_o = 7'd127;
        else if (x_i[X_W-1])
            a_o = neg_x[A_W-1:0];
        else
            a_o = x_i[A_W-1:0];
    end

    always_comb begin
        seg_o = S0;
        lb    = LB_S0;
        if (a_o >= LB_S6) begin
            seg_o = S6; lb = LB_S6;
        end else if (a_o >= LB_S5) begin
            seg_o = S5; lb = LB_S5;
        end else if (a_o >= LB_S4) begin
            seg_o = S4; lb = LB_S4;
        end else if (a_o >= LB_S3) begin
            seg_o = S3; lb = LB_S3;
        end else if (a_o >= LB_S2) begin
            seg_o = S2; lb = LB_S2;
        end else if (a_o >= LB_S1) begin
            seg_o = S1; lb = LB_S1;
        end
    end

    assign d_o = a_o - lb;

endmodule

// File: rtl/atanh_piecewise_stream.sv
// Two-stage valid/ready stream computing piecewise atanh(y): Q0.7 in, Q3.5 out.
// Optional saturating clip counter enabled by defining ATANH_CLIP_CNT_EN.
module atanh_piecewise_stream
    import atanh_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int CLIP_THRESH = 127
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [X_W-1:0] x_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [Y_W-1:0] y_out
`ifdef ATANH_CLIP_CNT_EN
    ,
    output logic [CNT_W-1:0] clip_count
`endif
);

    logic           dec_sign;
    logic [A_W-1:0] dec_a;
    seg_t           dec_seg;
    logic [D_W-1:0] dec_d;

    logic           s1_valid_q;
    logic           s1_sign_q;
    logic [A_W-1:0] s1_a_q;
    seg_t           s1_seg_q;
    logic [D_W-1:0] s1_d_q;

    logic           out_valid_q;
    logic [Y_W-1:0] y_q;
    logic [Y_W-1:0] y_d;
    logic [M_W-1:0] mag;

    logic s1_advance;
    logic accept;

    atanh_seg_decode u_dec (
        .x_i    (x_in),
        .sign_o (dec_sign),
        .a_o    (dec_a),
        .seg_o  (dec_seg),
        .d_o    (dec_d)
    );

    assign s1_advance = !out_valid_q || out_ready;
    assign in_ready   = !s1_valid_q || s1_advance;
    assign accept     = in_valid && in_ready;

    assign mag = seg_mag(s1_seg_q, s1_a_q, s1_d_q);
    assign y_d = s1_sign_q ? -mag : mag;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_a_q      <= '0;
            s1_seg_q    <= S0;
            s1_d_q      <= '0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_sign_q <= dec_sign;
                    s1_a_q    <= dec_a;
                    s1_seg_q  <= dec_seg;
                    s1_d_q    <= dec_d;
                end
            end
            // Output register only moves when downstream is free, so y_out holds under stall.
            if (s1_advance) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q)
                    y_q <= y_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign y_out     = y_q;

`ifdef ATANH_CLIP_CNT_EN
    logic [CNT_W-1:0] clip_q;

    always_ff @(posedge clk) begin
        if (reset)
            clip_q <= '0;
        else if (accept && (int'(dec_a) >= CLIP_THRESH) && (clip_q != {CNT_W{1'b1}}))
            clip_q <= clip_q + 1'b1;
    end

    assign clip_count = clip_q;
`else
    logic unused_cfg;
    assign unused_cfg = accept ^ (CNT_W == 0) ^ (CLIP_THRESH == 0);
`endif

endmodule
